// File: rtl/instr_emit.sv
// Serializes buffered instructions into a gapless 6-bit word stream for instr_fetch.
// A single sync word follows reset. Idle cycles carry IDLE_WORD.
module instr_emit #(
  parameter int          DEPTH     = 4,
  parameter logic [5:0]  IDLE_WORD = 6'o00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [2:0]               in_src_a,
  input  logic [2:0]               in_src_b,
  input  logic [2:0]               in_dest,
  input  logic [7:0]               in_imm,
  output logic [5:0]               out,
  output logic                     out_first,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_SYNC, S_W1, S_W2, S_W3} state_t;

  // FIFO entry layout: {opcode, src_a, src_b, dest, imm}
  logic [19:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q;
  logic          push, pop;
  logic [19:0]   head;

  // Current instruction keeps only what later words need: {opcode, src_b, dest, imm}
  logic [16:0]   cur_q, cur_d;
  state_t        state_q, state_d;
  logic [5:0]    out_q, out_d;
  logic          first_q, first_d;
  logic          last_q, last_d;

  function automatic logic isImm(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd4) || (op == 3'd6) || (op == 3'd7);
  endfunction

  assign push    = in_valid && ready_q;
  assign head    = mem_q[rd_ptr_q];
  assign level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_opcode, in_src_a, in_src_b, in_dest, in_imm};
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      ready_q <= (level_d != LW'(DEPTH));
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    out_d   = IDLE_WORD;
    first_d = 1'b0;
    last_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_SYNC: begin
        out_d   = 6'o77;
        state_d = S_W1;
      end
      S_W1: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          cur_d   = {head[19:17], head[13:0]};
          out_d   = head[19:14];
          first_d = 1'b1;
          if (head[19:17] == 3'd0) last_d = 1'b1;
          else                     state_d = S_W2;
        end
      end
      S_W2: begin
        out_d = {cur_q[10:8], isImm(cur_q[16:14]) ? cur_q[7:5] : cur_q[13:11]};
        if (isImm(cur_q[16:14])) begin
          state_d = S_W3;
        end else begin
          last_d  = 1'b1;
          state_d = S_W1;
        end
      end
      S_W3: begin
        out_d   = {1'b0, cur_q[4:0]};
        last_d  = 1'b1;
        state_d = S_W1;
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_SYNC;
      cur_q   <= '0;
      out_q   <= 6'o00;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      out_q   <= out_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign out        = out_q;
  assign out_first  = first_q;
  assign out_last   = last_q;
  assign in_ready   = ready_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_instr_emit.sv
// Bench for instr_emit: queue-based model of accepted instructions and the expected
// word stream, compared cycle by cycle against the DUT outputs.
module tb_instr_emit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [2:0] inOpcode = '0, inSrcA = '0, inSrcB = '0, inDest = '0;
  logic [7:0] inImm = '0;
  logic [5:0] outWord;
  logic       outFirst, outLast;
  logic [2:0] fifoLevel;

  int checks = 0;
  int failures = 0;

  // Model state: queued instructions and the remaining words of the one being sent
  logic [19:0] fifoQ[$];
  logic [7:0]  pendQ[$];
  bit          syncPending;
  bit          lastAccept;
  logic [5:0]  expOut;
  logic        expFirst, expLast, expReady;
  logic [2:0]  expLevel;

  instr_emit #(.DEPTH(DEPTH), .IDLE_WORD(6'o00)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady),
    .in_opcode(inOpcode), .in_src_a(inSrcA), .in_src_b(inSrcB),
    .in_dest(inDest), .in_imm(inImm),
    .out(outWord), .out_first(outFirst), .out_last(outLast),
    .fifo_level(fifoLevel)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    fifoQ.delete();
    pendQ.delete();
    syncPending = 1'b1;
    expOut = 6'o00; expFirst = 1'b0; expLast = 1'b0; expReady = 1'b1; expLevel = 3'd0;
  endtask

  task automatic expand(input logic [19:0] h);
    logic [2:0] op, a, b, d;
    logic [7:0] imm;
    {op, a, b, d, imm} = h;
    if (op == 3'd0) begin
      pendQ.push_back({2'b11, op, a});
    end else if (op inside {3'd2, 3'd4, 3'd6, 3'd7}) begin
      pendQ.push_back({2'b10, op, a});
      pendQ.push_back({2'b00, d, imm[7:5]});
      pendQ.push_back({2'b01, 1'b0, imm[4:0]});
    end else begin
      pendQ.push_back({2'b10, op, a});
      pendQ.push_back({2'b01, d, b});
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelEdge();
    logic [7:0] w;
    lastAccept = inValid && (fifoQ.size() < DEPTH);
    if (syncPending) begin
      syncPending = 1'b0;
      {expFirst, expLast, expOut} = {2'b00, 6'o77};
    end else begin
      if (pendQ.size() == 0 && fifoQ.size() > 0) expand(fifoQ.pop_front());
      if (pendQ.size() > 0) begin
        w = pendQ.pop_front();
        {expFirst, expLast, expOut} = w;
      end else begin
        {expFirst, expLast, expOut} = {2'b00, 6'o00};
      end
    end
    if (lastAccept) fifoQ.push_back({inOpcode, inSrcA, inSrcB, inDest, inImm});
    expLevel = 3'(fifoQ.size());
    expReady = (fifoQ.size() < DEPTH);
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({outWord, outFirst, outLast, inReady, fifoLevel} !== {6'o00, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL reset_state: got out=%o f=%b l=%b rdy=%b lvl=%0d, want out=00 f=0 l=0 rdy=1 lvl=0",
               outWord, outFirst, outLast, inReady, fifoLevel);
    end
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({outWord, outFirst, outLast, inReady, fifoLevel} !== {expOut, expFirst, expLast, expReady, expLevel}) begin
        failures++;
        $display("FAIL sync_idle[%0d]: got out=%o f=%b l=%b rdy=%b lvl=%0d, want out=%o f=%b l=%b rdy=%b lvl=%0d",
                 i, outWord, outFirst, outLast, inReady, fifoLevel, expOut, expFirst, expLast, expReady, expLevel);
      end
    end
  endtask

  task automatic test_two_word();
    logic [7:0] obs [4];
    logic [7:0] want [3];
    want[0] = {2'b10, 6'o12}; want[1] = {2'b01, 6'o35}; want[2] = {2'b00, 6'o00};
    {inOpcode, inSrcA, inSrcB, inDest, inImm} = {3'd1, 3'd2, 3'd5, 3'd3, 8'h00};
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      obs[i] = {outFirst, outLast, outWord};
      checks++;
      if ({outWord, outFirst, outLast, inReady, fifoLevel} !== {expOut, expFirst, expLast, expReady, expLevel}) begin
        failures++;
        $display("FAIL two_word_model[%0d]: got out=%o f=%b l=%b rdy=%b lvl=%0d, want out=%o f=%b l=%b rdy=%b lvl=%0d",
                 i, outWord, outFirst, outLast, inReady, fifoLevel, expOut, expFirst, expLast, expReady, expLevel);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== want[i]) begin
        failures++;
        $display("FAIL two_word_seq[%0d]: got {f,l,out}=%b_%o, want %b_%o", i, obs[i][7:6], obs[i][5:0], want[i][7:6], want[i][5:0]);
      end
    end
  endtask

  task automatic test_imm();
    logic [7:0] obs [4];
    logic [7:0] want [4];
    want[0] = {2'b10, 6'o21}; want[1] = {2'b00, 6'o45}; want[2] = {2'b01, 6'h07}; want[3] = {2'b00, 6'o00};
    {inOpcode, inSrcA, inSrcB, inDest, inImm} = {3'd2, 3'd1, 3'd0, 3'd4, 8'hA7};
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      obs[i] = {outFirst, outLast, outWord};
      checks++;
      if (obs[i] !== want[i]) begin
        failures++;
        $display("FAIL imm_seq[%0d]: got {f,l,out}=%b_%o, want %b_%o", i, obs[i][7:6], obs[i][5:0], want[i][7:6], want[i][5:0]);
      end
    end
  endtask

  task automatic test_full();
    int accepted = 0;
    int cyc = 0;
    bit sawFull = 1'b0;
    inValid = 1'b1;
    {inOpcode, inSrcA, inSrcB, inDest, inImm} = {3'd6, 3'($urandom), 3'd0, 3'($urandom), 8'($urandom)};
    while (accepted < 6 && cyc < 100) begin
      tick();
      cyc++;
      if (lastAccept) begin
        accepted++;
        {inSrcA, inDest, inImm} = {3'($urandom), 3'($urandom), 8'($urandom)};
      end
      if (fifoLevel == 3'd4 && inReady == 1'b0) sawFull = 1'b1;
      checks++;
      if ({outWord, outFirst, outLast, inReady, fifoLevel} !== {expOut, expFirst, expLast, expReady, expLevel}) begin
        failures++;
        $display("FAIL full_fill[%0d]: got out=%o f=%b l=%b rdy=%b lvl=%0d, want out=%o f=%b l=%b rdy=%b lvl=%0d",
                 cyc, outWord, outFirst, outLast, inReady, fifoLevel, expOut, expFirst, expLast, expReady, expLevel);
      end
    end
    inValid = 1'b0;
    checks++;
    if (accepted != 6 || !sawFull) begin
      failures++;
      $display("FAIL full_reached: got accepted=%0d sawFull=%b, want accepted=6 sawFull=1", accepted, sawFull);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if ({outWord, outFirst, outLast, inReady, fifoLevel} !== {expOut, expFirst, expLast, expReady, expLevel}) begin
        failures++;
        $display("FAIL full_drain[%0d]: got out=%o f=%b l=%b rdy=%b lvl=%0d, want out=%o f=%b l=%b rdy=%b lvl=%0d",
                 i, outWord, outFirst, outLast, inReady, fifoLevel, expOut, expFirst, expLast, expReady, expLevel);
      end
    end
  endtask

  task automatic test_reset_mid();
    inValid = 1'b1;
    {inOpcode, inSrcA, inSrcB, inDest, inImm} = {3'd3, 3'd1, 3'd2, 3'd3, 8'h00};
    tick();
    {inOpcode, inSrcA} = {3'd5, 3'd7};
    tick();
    inValid = 1'b0;
    checks++;
    if ({outWord, outFirst, fifoLevel} !== {expOut, expFirst, expLevel} || expFirst !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: got out=%o f=%b lvl=%0d, want out=%o f=1 lvl=%0d", outWord, outFirst, fifoLevel, expOut, expLevel);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({outWord, outFirst, outLast, inReady, fifoLevel} !== {6'o00, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL mid_reset: got out=%o f=%b l=%b rdy=%b lvl=%0d, want out=00 f=0 l=0 rdy=1 lvl=0",
               outWord, outFirst, outLast, inReady, fifoLevel);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({outWord, outFirst, outLast, inReady, fifoLevel} !== {expOut, expFirst, expLast, expReady, expLevel}) begin
        failures++;
        $display("FAIL mid_after[%0d]: got out=%o f=%b l=%b rdy=%b lvl=%0d, want out=%o f=%b l=%b rdy=%b lvl=%0d",
                 i, outWord, outFirst, outLast, inReady, fifoLevel, expOut, expFirst, expLast, expReady, expLevel);
      end
    end
  endtask

  task automatic test_random();
    int accepted = 0;
    int cyc = 0;
    int errs = 0;
    while (accepted < 500 && cyc < 20000) begin
      inValid = ($urandom_range(0, 3) != 0);
      {inOpcode, inSrcA, inSrcB, inDest, inImm} = 20'($urandom);
      tick();
      cyc++;
      if (lastAccept) accepted++;
      checks++;
      if ({outWord, outFirst, outLast, inReady, fifoLevel} !== {expOut, expFirst, expLast, expReady, expLevel}) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: got out=%o f=%b l=%b rdy=%b lvl=%0d, want out=%o f=%b l=%b rdy=%b lvl=%0d",
                   cyc, outWord, outFirst, outLast, inReady, fifoLevel, expOut, expFirst, expLast, expReady, expLevel);
      end
    end
    inValid = 1'b0;
    cyc = 0;
    while ((fifoQ.size() > 0 || pendQ.size() > 0) && cyc < 100) begin
      tick();
      cyc++;
      checks++;
      if ({outWord, outFirst, outLast, inReady, fifoLevel} !== {expOut, expFirst, expLast, expReady, expLevel}) begin
        failures++;
        $display("FAIL random_drain[%0d]: got out=%o f=%b l=%b, want out=%o f=%b l=%b",
                 cyc, outWord, outFirst, outLast, expOut, expFirst, expLast);
      end
    end
    checks++;
    if (accepted != 500 || fifoQ.size() != 0 || pendQ.size() != 0) begin
      failures++;
      $display("FAIL random_bound: got accepted=%0d queued=%0d, want accepted=500 queued=0", accepted, fifoQ.size() + pendQ.size());
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_two_word();
    test_imm();
    test_full();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
